write_response_credit_bridge: RTL and testbench

Parametrised successor to the team's write-response pipeline bridge. It sits between a bursting Avalon-MM write master (DMA write engine) and the host-memory write port. Both directions are fully registered. The command path uses a 2-entry skid buffer, so s_waitrequest is never a straight copy of m_waitrequest. The outstanding-burst limit accepts any value, not only powers of two, and the block reports pending count, idle state and a sticky response error.

---
 rtl/write_response_credit_bridge.sv | 153 +++++++++++++++
 tb/tb_write_response_credit_bridge.sv | 293 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/write_response_credit_bridge.sv
// rtl/write_response_credit_bridge.sv - registered Avalon-MM write bridge with skid buffer, burst credit and sticky error
module write_response_credit_bridge #(
    parameter int ADDRESS_WIDTH      = 48,
    parameter int DATA_WIDTH         = 512,
    parameter int MAX_BURST          = 4,
    parameter int MAX_PENDING_WRITES = 32,
    parameter int BURST_WIDTH        = $clog2(MAX_BURST) + 1,
    parameter int PENDING_WIDTH      = $clog2(MAX_PENDING_WRITES + 1)
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic [ADDRESS_WIDTH-1:0]   s_address,
    input  logic [DATA_WIDTH-1:0]      s_writedata,
    input  logic                       s_write,
    input  logic [DATA_WIDTH/8-1:0]    s_byteenable,
    input  logic [BURST_WIDTH-1:0]     s_burst,
    output logic                       s_waitrequest,
    output logic [1:0]                 s_response,
    output logic                       s_write_response_valid,
    output logic [ADDRESS_WIDTH-1:0]   m_address,
    output logic [DATA_WIDTH-1:0]      m_writedata,
    output logic                       m_write,
    output logic [DATA_WIDTH/8-1:0]    m_byteenable,
    output logic [BURST_WIDTH-1:0]     m_burst,
    input  logic                       m_waitrequest,
    input  logic [1:0]                 m_response,
    input  logic                       m_write_response_valid,
    output logic [PENDING_WIDTH-1:0]   pending_count,
    output logic                       idle,
    input  logic                       clear_error,
    output logic                       error_sticky
);
    localparam logic [PENDING_WIDTH-1:0] MAX_PEND = PENDING_WIDTH'(MAX_PENDING_WRITES);

    logic                      r_m_write;
    logic [ADDRESS_WIDTH-1:0]  r_m_addr;
    logic [DATA_WIDTH-1:0]     r_m_data;
    logic [DATA_WIDTH/8-1:0]   r_m_be;
    logic [BURST_WIDTH-1:0]    r_m_burst;
    logic                      r_sk_valid;
    logic [ADDRESS_WIDTH-1:0]  r_sk_addr;
    logic [DATA_WIDTH-1:0]     r_sk_data;
    logic [DATA_WIDTH/8-1:0]   r_sk_be;
    logic [BURST_WIDTH-1:0]    r_sk_burst;
    logic [BURST_WIDTH-1:0]    r_burst_cnt;
    logic [BURST_WIDTH-1:0]    r_cur_burst;
    logic [PENDING_WIDTH-1:0]  r_pending;
    logic                      r_wait;
    logic [1:0]                r_resp;
    logic                      r_resp_valid;
    logic                      r_idle;
    logic                      r_err;

    logic                      w_accept;
    logic                      w_first;
    logic [BURST_WIDTH-1:0]    w_beat_burst;
    logic                      w_main_free;
    logic                      w_skid_next;
    logic [BURST_WIDTH-1:0]    w_cnt_next;
    logic                      w_inc;
    logic                      w_dec;
    logic [PENDING_WIDTH-1:0]  w_pending_next;
    logic                      w_credit_next;

    assign w_accept     = s_write & ~r_wait;
    assign w_first      = (r_burst_cnt == '0);
    // Later beats carry the burstcount latched from the first beat, not the live s_burst.
    assign w_beat_burst = w_first ? s_burst : r_cur_burst;
    assign w_main_free  = ~r_m_write | ~m_waitrequest;
    assign w_skid_next  = r_sk_valid ? (~w_main_free | w_accept) : (w_accept & ~w_main_free);
    assign w_cnt_next   = w_accept ? (w_first ? s_burst - 1'b1 : r_burst_cnt - 1'b1) : r_burst_cnt;
    assign w_inc        = w_accept & w_first;
    assign w_dec        = r_resp_valid;

    always_comb begin
        w_pending_next = r_pending;
        if (w_inc && !w_dec) begin
            w_pending_next = r_pending + 1'b1;
        end else if (w_dec && !w_inc && r_pending != '0) begin
            w_pending_next = r_pending - 1'b1;
        end
    end

    assign w_credit_next = (w_pending_next >= MAX_PEND) && (w_cnt_next == '0);

    always_ff @(posedge clk) begin
        if (reset) begin
            r_m_write    <= 1'b0;
            r_sk_valid   <= 1'b0;
            r_burst_cnt  <= '0;
            r_pending    <= '0;
            r_wait       <= 1'b1;
            r_resp       <= 2'b00;
            r_resp_valid <= 1'b0;
            r_idle       <= 1'b1;
            r_err        <= 1'b0;
        end else begin
            if (w_main_free) begin
                r_m_write <= r_sk_valid | w_accept;
            end
            r_sk_valid   <= w_skid_next;
            r_burst_cnt  <= w_cnt_next;
            r_pending    <= w_pending_next;
            r_wait       <= w_skid_next | w_credit_next;
            r_resp       <= m_response;
            r_resp_valid <= m_write_response_valid;
            r_idle       <= (w_pending_next == '0) && !w_skid_next && (w_cnt_next == '0);
            if (r_resp_valid && r_resp != 2'b00) begin
                r_err <= 1'b1;
            end else if (clear_error) begin
                r_err <= 1'b0;
            end
        end
    end

    // Payload registers carry no reset; their valid flags above qualify them.
    always_ff @(posedge clk) begin
        if (w_main_free) begin
            if (r_sk_valid) begin
                r_m_addr  <= r_sk_addr;
                r_m_data  <= r_sk_data;
                r_m_be    <= r_sk_be;
                r_m_burst <= r_sk_burst;
            end else if (w_accept) begin
                r_m_addr  <= s_address;
                r_m_data  <= s_writedata;
                r_m_be    <= s_byteenable;
                r_m_burst <= w_beat_burst;
            end
        end
        if (w_accept && (!w_main_free || r_sk_valid)) begin
            r_sk_addr  <= s_address;
            r_sk_data  <= s_writedata;
            r_sk_be    <= s_byteenable;
            r_sk_burst <= w_beat_burst;
        end
        if (w_accept && w_first) begin
            r_cur_burst <= s_burst;
        end
    end

    assign s_waitrequest          = r_wait;
    assign s_response             = r_resp;
    assign s_write_response_valid = r_resp_valid;
    assign m_address              = r_m_addr;
    assign m_writedata            = r_m_data;
    assign m_write                = r_m_write;
    assign m_byteenable           = r_m_be;
    assign m_burst                = r_m_burst;
    assign pending_count          = r_pending;
    assign idle                   = r_idle;
    assign error_sticky           = r_err;
endmodule

// File: tb/tb_write_response_credit_bridge.sv
// tb/tb_write_response_credit_bridge.sv - scoreboard bench for write_response_credit_bridge
module tb_write_response_credit_bridge;
    localparam int AW = 16;
    localparam int DW = 32;
    localparam int BW = 3;
    localparam int PW = 2;

    logic          clk = 1'b0;
    logic          reset;
    logic [AW-1:0] s_address;
    logic [DW-1:0] s_writedata;
    logic          s_write;
    logic [3:0]    s_byteenable;
    logic [BW-1:0] s_burst;
    logic          s_waitrequest;
    logic [1:0]    s_response;
    logic          s_write_response_valid;
    logic [AW-1:0] m_address;
    logic [DW-1:0] m_writedata;
    logic          m_write;
    logic [3:0]    m_byteenable;
    logic [BW-1:0] m_burst;
    logic          m_waitrequest;
    logic [1:0]    m_response;
    logic          m_write_response_valid;
    logic [PW-1:0] pending_count;
    logic          idle;
    logic          clear_error;
    logic          error_sticky;

    write_response_credit_bridge #(
        .ADDRESS_WIDTH(AW), .DATA_WIDTH(DW), .MAX_BURST(4), .MAX_PENDING_WRITES(3)
    ) dut (
        .clk(clk), .reset(reset),
        .s_address(s_address), .s_writedata(s_writedata), .s_write(s_write),
        .s_byteenable(s_byteenable), .s_burst(s_burst), .s_waitrequest(s_waitrequest),
        .s_response(s_response), .s_write_response_valid(s_write_response_valid),
        .m_address(m_address), .m_writedata(m_writedata), .m_write(m_write),
        .m_byteenable(m_byteenable), .m_burst(m_burst), .m_waitrequest(m_waitrequest),
        .m_response(m_response), .m_write_response_valid(m_write_response_valid),
        .pending_count(pending_count), .idle(idle),
        .clear_error(clear_error), .error_sticky(error_sticky)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [AW-1:0] a;
        logic [DW-1:0] d;
        logic [3:0]    be;
        logic [BW-1:0] b;
    } beat_t;
    typedef struct {
        logic [1:0] r;
        int         c;
    } resp_t;

    beat_t exp_beats[$];
    resp_t exp_resp[$];
    beat_t mon_b;
    resp_t mon_r;
    int    cyc = 0;
    int    n_pass = 0;
    int    n_total = 0;
    int    st, acc, rcyc;

    always @(posedge clk) cyc++;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", name, act, exp);
    endtask

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    // Downstream monitor: every completed m_* transfer must match the next accepted beat.
    always @(negedge clk) begin
        if (m_write === 1'b1 && m_waitrequest === 1'b0) begin
            if (exp_beats.size() == 0) begin
                check("beat_unexpected", {48'h0, m_address}, 64'hdead);
            end else begin
                mon_b = exp_beats.pop_front();
                check("beat_addr", {48'h0, m_address}, {48'h0, mon_b.a});
                check("beat_data", {32'h0, m_writedata}, {32'h0, mon_b.d});
                check("beat_be", {60'h0, m_byteenable}, {60'h0, mon_b.be});
                check("beat_burst", {61'h0, m_burst}, {61'h0, mon_b.b});
            end
        end
    end

    always @(negedge clk) begin
        if (s_write_response_valid === 1'b1) begin
            if (exp_resp.size() == 0) begin
                check("resp_unexpected", 64'h1, 64'h0);
            end else begin
                mon_r = exp_resp.pop_front();
                check("resp_code", {62'h0, s_response}, {62'h0, mon_r.r});
                check("resp_latency", cyc, mon_r.c + 1);
            end
        end
    end

    task automatic send_beat(input logic [AW-1:0] a, input logic [BW-1:0] b, input logic [BW-1:0] burst_len,
                             output int stalls, output int acc_cyc);
        beat_t e;
        s_address = a;
        s_writedata = {a, ~a};
        s_byteenable = a[5:2];
        s_burst = b;
        s_write = 1'b1;
        stalls = 0;
        acc_cyc = 0;
        e.a = a; e.d = {a, ~a}; e.be = a[5:2]; e.b = burst_len;
        forever begin
            @(negedge clk);
            if (s_waitrequest === 1'b0) begin
                exp_beats.push_back(e);
                @(posedge clk);
                #1;
                s_write = 1'b0;
                acc_cyc = cyc;
                return;
            end
            stalls++;
            if (stalls > 100) begin
                check("accept_timeout", 64'h0, 64'h1);
                s_write = 1'b0;
                return;
            end
            @(posedge clk);
            #1;
        end
    endtask

    task automatic send_burst(input logic [AW-1:0] base, input int n, output int total);
        int s, c;
        total = 0;
        for (int i = 0; i < n; i++) begin
            send_beat(base + AW'(i * 4), (i == 0) ? BW'(n) : BW'(0), BW'(n), s, c);
            total += s;
        end
    endtask

    task automatic respond(input logic [1:0] r);
        resp_t e;
        e.r = r;
        e.c = cyc;
        exp_resp.push_back(e);
        m_response = r;
        m_write_response_valid = 1'b1;
        @(posedge clk);
        #1;
        m_write_response_valid = 1'b0;
        m_response = 2'b00;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, cycle %0d expected under 20000", cyc);
        $fatal(1);
    end

    initial begin
        reset = 1'b1; s_write = 1'b0; s_address = '0; s_writedata = '0; s_byteenable = '0; s_burst = '0;
        m_waitrequest = 1'b0; m_response = 2'b00; m_write_response_valid = 1'b0; clear_error = 1'b0;
        tick(3);
        check("rst_m_write", m_write, 0);
        check("rst_s_wait", s_waitrequest, 1);
        check("rst_pending", pending_count, 0);
        check("rst_idle", idle, 1);
        check("rst_err", error_sticky, 0);
        check("rst_resp_valid", s_write_response_valid, 0);
        check("rst_resp", s_response, 0);
        reset = 1'b0;
        tick(1);
        check("post_rst_s_wait", s_waitrequest, 0);

        // Single 4-beat burst, unstalled.
        send_burst(16'h1000, 4, st);
        check("b1_stalls", st, 0);
        check("b1_pending", pending_count, 1);
        check("b1_idle", idle, 0);
        tick(10);
        respond(2'b00);
        tick(1);
        check("b1_pending_done", pending_count, 0);
        check("b1_idle_done", idle, 1);

        // Backpressure: downstream stalls 5 cycles during a burst.
        m_waitrequest = 1'b1;
        fork
            send_burst(16'h2000, 4, st);
            begin
                tick(3);
                check("bp_s_wait", s_waitrequest, 1);
                check("bp_m_write", m_write, 1);
                check("bp_m_addr_hold", m_address, 16'h2000);
                tick(2);
                m_waitrequest = 1'b0;
            end
        join
        check("bp_stalled", st > 0, 1);
        tick(3);
        respond(2'b00);
        tick(1);
        check("bp_pending_done", pending_count, 0);

        // Credit limit of 3 with a mid-burst crossing of the limit.
        send_burst(16'h3000, 2, st);
        send_burst(16'h3100, 2, st);
        send_burst(16'h3200, 2, st);
        check("cr_midburst_no_stall", st, 0);
        check("cr_pending_full", pending_count, 3);
        fork
            send_beat(16'h3300, 3'd2, 3'd2, st, acc);
            begin
                tick(5);
                check("cr_s_wait_blocked", s_waitrequest, 1);
                check("cr_pending_blocked", pending_count, 3);
                rcyc = cyc + 1;
                respond(2'b00);
            end
        join
        check("cr_release_latency", (acc > rcyc) && (acc - rcyc <= 2), 1);
        send_beat(16'h3304, 3'd0, 3'd2, st, acc);
        check("cr_pending_after", pending_count, 3);
        respond(2'b00);
        respond(2'b00);
        respond(2'b00);
        tick(2);
        check("cr_pending_drain", pending_count, 0);
        check("cr_idle_drain", idle, 1);

        // Error flag behaviour, plus one-cycle latency of a single-beat burst.
        send_beat(16'h4000, 3'd1, 3'd1, st, acc);
        check("lat_m_write", m_write, 1);
        check("lat_m_addr", m_address, 16'h4000);
        send_beat(16'h4010, 3'd1, 3'd1, st, acc);
        tick(2);
        respond(2'b10);
        check("err_not_yet", error_sticky, 0);
        tick(1);
        check("err_set", error_sticky, 1);
        respond(2'b01);
        clear_error = 1'b1;
        tick(1);
        clear_error = 1'b0;
        check("err_set_wins", error_sticky, 1);
        clear_error = 1'b1;
        tick(1);
        clear_error = 1'b0;
        check("err_cleared", error_sticky, 0);
        check("err_pending", pending_count, 0);

        // Reset during the second beat of a burst with two bursts pending.
        send_beat(16'h5000, 3'd1, 3'd1, st, acc);
        send_beat(16'h5100, 3'd4, 3'd4, st, acc);
        check("mr_pending_before", pending_count, 2);
        s_address = 16'h5104;
        s_burst = 3'd0;
        s_write = 1'b1;
        reset = 1'b1;
        tick(1);
        reset = 1'b0;
        s_write = 1'b0;
        check("mr_m_write", m_write, 0);
        check("mr_pending", pending_count, 0);
        check("mr_idle", idle, 1);
        check("mr_s_wait", s_waitrequest, 1);
        tick(1);
        check("mr_s_wait_after", s_waitrequest, 0);
        send_burst(16'h6000, 2, st);
        check("mr_new_stalls", st, 0);
        check("mr_new_pending", pending_count, 1);
        respond(2'b00);
        tick(1);
        check("mr_new_done", pending_count, 0);
        check("mr_new_idle", idle, 1);
        respond(2'b00);
        tick(1);
        check("mr_saturate", pending_count, 0);

        tick(5);
        check("beats_left", exp_beats.size(), 0);
        check("resps_left", exp_resp.size(), 0);
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end
endmodule
